match_event_logger: RTL and testbench
=====================================

// Module: match_event_logger
// PURPOSE
//   Consumes the one-cycle 'found' pulses from the serial pattern recogniser and logs each match.
//   Keeps a saturating match count and a free-running cycle timestamp.
//   Queues the timestamp of every match in a small FIFO that a downstream reader drains over a
//   valid/ready handshake. Sticky overflow flags any match lost to a full FIFO.
// PARAMETERS
//   TS_W    16  width of timestamp counter and evt_ts
//   CNT_W   16  width of match_count (saturating)
//   DEPTH   8   FIFO entries; power of two, >= 2
//   ADDR_W  3   log2(DEPTH); pointer width
// PORTS
//   clk          in   1          clock, all state updates on rising edge
//   rst          in   1          reset, synchronous, active-high
//   en           in   1          logging enable; gates timestamp advance and match capture
//   clr          in   1          synchronous soft clear (see BEHAVIOUR)
//   found        in   1          match pulse from pattern recogniser; one event per high cycle
//   evt_valid    out  1          FIFO non-empty; evt_ts holds oldest entry
//   evt_ready    in   1          reader accepts evt_ts this cycle
//   evt_ts       out  TS_W       timestamp of oldest logged match
//   match_count  out  CNT_W      total matches seen since rst/clr, saturating
//   overflow     out  1          sticky: a match was dropped because FIFO was full
//   fifo_level   out  ADDR_W+1   number of entries held, 0..DEPTH
// BEHAVIOUR
//   Reset (rst=1 at clk edge): ts=0, match_count=0, overflow=0, rd/wr ptrs=0, fifo_level=0,
//     evt_valid=0. evt_ts is don't-care while evt_valid=0. rst overrides clr and all events.
//   Timestamp: ts += 1 (mod 2^TS_W) each cycle with en=1; holds when en=0. 0xFFFF wraps to 0.
//   Event: cycle with found=1 && en=1 && clr=0. Captured value is ts of that cycle (pre-increment).
//     found with en=0 is ignored entirely (no count, no FIFO, no overflow).
//   match_count: +1 per event; saturates at 2^CNT_W-1 and holds there.
//   Pop: evt_valid && evt_ready. evt_ready with evt_valid=0 is ignored.
//   Push: event && (fifo_level < DEPTH || pop). Push+pop same cycle when full is accepted,
//     fifo_level unchanged. Event with fifo_level==DEPTH and no pop: dropped, overflow<=1
//     (still counted in match_count).
//   Latency: event at edge N -> evt_valid=1 and entry visible after edge N (cycle N+1) when FIFO
//     was empty. Push+pop in same cycle on an empty FIFO is impossible (evt_valid=0).
//   evt_ts = mem[rd_ptr], first-word-fall-through; stable while evt_valid && !evt_ready.
//   Order: strict FIFO; pointers wrap modulo DEPTH.
//   evt_valid = (fifo_level != 0); fifo_level updates +1 push-only, -1 pop-only, 0 both/neither.
//   clr=1: ts<=0, match_count<=0, overflow<=0, FIFO flushed (level 0); found that cycle discarded,
//     pending pop that cycle discarded. clr mid-burst leaves no stale entries.
//   Back-to-back found pulses are each separate events (no edge detect).
//   No X propagation: all registers except FIFO storage are reset.
// TESTING
//   rst, en=1, found pulse at ts=5, evt_ready=0 -> next cycle evt_valid=1, evt_ts=5, match_count=1, fifo_level=1.
//   9 found pulses, evt_ready=0, DEPTH=8 -> fifo_level=8, overflow=1, match_count=9; drain returns 8 ts in order.
//   FIFO full, found=1 and evt_ready=1 same cycle -> level stays 8, overflow stays 0, new ts at tail.
//   Preload ts to 0xFFFE via 2^16-2 en cycles, found at 0xFFFF and next cycle -> evt_ts 0xFFFF then 0x0000.
//   en=0 with found=1 for 10 cycles -> ts, match_count, fifo_level unchanged; overflow=0.
//   3 entries queued, overflow=1, clr=1 with found=1 -> next cycle level=0, evt_valid=0, count=0, overflow=0, ts=0.

Source files
------------

// File: rtl/match_event_logger.sv
// Logs 'found' match pulses: saturating match count, free-running timestamp,
// and a FWFT FIFO of match timestamps drained over valid/ready with sticky overflow.
module match_event_logger #(
  parameter int unsigned TS_W   = 16,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              found,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [TS_W-1:0]   evt_ts,
  output logic [CNT_W-1:0]  match_count,
  output logic              overflow,
  output logic [ADDR_W:0]   fifo_level
);

  localparam int unsigned LVL_W = ADDR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [TS_W-1:0]   mem_q [DEPTH];

  logic event_c, pop_c, push_c, full_c;

  // Event qualification; clr discards both the incoming match and any pending pop.
  always_comb begin
    full_c  = (level_q == FULL_LVL);
    event_c = found && en && !clr;
    pop_c   = (level_q != '0) && evt_ready && !clr;
    push_c  = event_c && (!full_c || pop_c);
  end

  // Next-state for counters, pointers and flags.
  always_comb begin
    ts_d       = ts_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;

    if (clr) begin
      ts_d       = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      level_d    = '0;
    end else begin
      if (en) begin
        ts_d = ts_q + TS_W'(1);
      end
      if (event_c && (count_q != CNT_MAX)) begin
        count_d = count_q + CNT_W'(1);
      end
      if (event_c && full_c && !pop_c) begin
        overflow_d = 1'b1;
      end
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      ts_q       <= ts_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
    end
  end

  // Storage is not reset; entries are only observable once written.
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      mem_q[wr_ptr_q] <= ts_q;
    end
  end

  assign evt_valid   = (level_q != '0);
  assign evt_ts      = mem_q[rd_ptr_q];
  assign match_count = count_q;
  assign overflow    = overflow_q;
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_match_event_logger.sv
// Directed bench for match_event_logger with hand-computed expectations.
module tb_match_event_logger;

  logic        clk = 1'b0;
  logic        rst, en, clr, found, evt_ready;
  logic        evt_valid, overflow;
  logic [15:0] evt_ts, match_count;
  logic [3:0]  fifo_level;

  // Narrow-counter instance sharing the stimulus, used to reach saturation quickly.
  logic        s_evt_valid, s_overflow;
  logic [15:0] s_evt_ts;
  logic [3:0]  s_match_count;
  logic [3:0]  s_fifo_level;

  int vectors = 0;
  int miscompares = 0;

  match_event_logger dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .found(found),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ts(evt_ts),
    .match_count(match_count), .overflow(overflow), .fifo_level(fifo_level)
  );

  match_event_logger #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .found(found),
    .evt_valid(s_evt_valid), .evt_ready(evt_ready), .evt_ts(s_evt_ts),
    .match_count(s_match_count), .overflow(s_overflow), .fifo_level(s_fifo_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; found = 1'b0; evt_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);

    // ts 0 -> 5, then one match captured at ts=5
    en = 1'b1;
    repeat (5) tick();
    found = 1'b1; tick(); found = 1'b0;
    chk("first_valid", 32'(evt_valid), 32'd1);
    chk("first_ts", 32'(evt_ts), 32'h5);
    chk("first_count", 32'(match_count), 32'd1);
    chk("first_level", 32'(fifo_level), 32'd1);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;           // ts now 7
    chk("pop_level", 32'(fifo_level), 32'd0);
    chk("pop_valid", 32'(evt_valid), 32'd0);

    // 9 matches (ts 7..15) into an empty 8-deep FIFO: last one dropped
    found = 1'b1; repeat (9) tick(); found = 1'b0;        // ts now 16
    chk("ovf_level", 32'(fifo_level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(match_count), 32'd10);
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain1_valid", 32'(evt_valid), 32'd1);
      chk("drain1_ts", 32'(evt_ts), 32'(7 + i));
      tick();
    end
    evt_ready = 1'b0;                                      // ts now 24
    chk("drain1_empty", 32'(evt_valid), 32'd0);
    chk("drain1_ovf_sticky", 32'(overflow), 32'd1);

    clr = 1'b1; tick(); clr = 1'b0;                        // ts now 0
    chk("clr1_ovf", 32'(overflow), 32'd0);
    chk("clr1_count", 32'(match_count), 32'd0);

    // Fill exactly (ts 0..7), then push+pop while full (captures ts 8)
    found = 1'b1; repeat (8) tick();
    chk("full_level", 32'(fifo_level), 32'd8);
    chk("full_ovf", 32'(overflow), 32'd0);
    evt_ready = 1'b1; tick(); found = 1'b0;                // ts now 9
    chk("pp_level", 32'(fifo_level), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_count", 32'(match_count), 32'd9);
    for (int i = 0; i < 8; i++) begin
      chk("drain2_ts", 32'(evt_ts), 32'(1 + i));
      tick();
    end
    evt_ready = 1'b0;                                      // ts now 17
    chk("drain2_level", 32'(fifo_level), 32'd0);

    // found with en=0 ignored; ts holds at 17
    en = 1'b0; found = 1'b1;
    repeat (10) tick();
    chk("en0_count", 32'(match_count), 32'd9);
    chk("en0_level", 32'(fifo_level), 32'd0);
    chk("en0_ovf", 32'(overflow), 32'd0);
    en = 1'b1; tick();                                     // captures 17
    chk("en1_ts", 32'(evt_ts), 32'h11);
    chk("en1_count", 32'(match_count), 32'd10);

    // 8 more matches: 7 fit, 1 dropped; narrow counter saturates at 15
    repeat (8) tick();
    chk("refill_level", 32'(fifo_level), 32'd8);
    chk("refill_ovf", 32'(overflow), 32'd1);
    chk("refill_count", 32'(match_count), 32'd18);
    chk("sat_count", 32'(s_match_count), 32'd15);

    // clr with found and evt_ready both high
    clr = 1'b1; evt_ready = 1'b1; tick();
    clr = 1'b0; evt_ready = 1'b0;
    chk("clr2_level", 32'(fifo_level), 32'd0);
    chk("clr2_valid", 32'(evt_valid), 32'd0);
    chk("clr2_count", 32'(match_count), 32'd0);
    chk("clr2_ovf", 32'(overflow), 32'd0);
    chk("clr2_sat_count", 32'(s_match_count), 32'd0);
    tick(); found = 1'b0;                                  // captures ts 0 after clr
    chk("clr2_ts", 32'(evt_ts), 32'h0);
    chk("clr2_count1", 32'(match_count), 32'd1);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;            // ts now 2

    // Timestamp wrap: advance to 0xFFFF, capture 0xFFFF and 0x0000
    repeat (65533) tick();
    found = 1'b1; tick(); tick(); found = 1'b0;
    chk("wrap_level", 32'(fifo_level), 32'd2);
    chk("wrap_ts_hi", 32'(evt_ts), 32'hFFFF);
    evt_ready = 1'b1; tick();
    chk("wrap_ts_lo", 32'(evt_ts), 32'h0);
    tick(); evt_ready = 1'b0;
    chk("wrap_empty", 32'(evt_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
